// File: rtl/wless_tx_scheduler.sv
// ---------------------------------------------------------------------------
// wless_tx_scheduler
//
// Decides when bytes held in the MCU receive buffer are forwarded to the
// wireless node UART. A packet starts immediately once the buffer holds at
// least START_WIRELESS_TRANS_VALUE bytes. A smaller amount is sent once the
// MCU has gone quiet for END_WAITING_SEND_WLESS_DATA cycles. At most
// MAX_PACKET bytes go out per packet. After a packet the scheduler waits
// for the node UART to report TX_complete before it considers the buffer
// again.
//
// Handshake: TX_use_node and buf_rd are one registered pulse driven from
// the same flop. In that cycle data_to_uart_node holds the byte that is
// pushed into the node UART and popped from the buffer. No push is issued
// while TX_flag_node (UART FIFO full) is high, and the scheduler holds for
// as long as needed. The buffer is expected to update buf_count/buf_data by
// the cycle after the pop pulse. The mandatory gap cycle after every issue
// gives it that time.
//
// Ports
//   internal_clk       in   clock, rising edge
//   rst                in   synchronous active-high reset
//   enable             in   mode allows wireless transmission
//   buf_count          in   bytes currently in the buffer
//   buf_data           in   head byte of the buffer
//   rx_byte_strobe     in   new MCU byte entered the buffer (restarts idle timer)
//   buf_rd             out  pop pulse to the buffer
//   TX_flag_node       in   node UART TX FIFO full
//   TX_complete        in   node UART has shifted out everything
//   TX_use_node        out  push pulse to the node UART
//   data_to_uart_node  out  byte pushed with TX_use_node
//   AUX                out  1 = idle, 0 = packet pending or in flight
//   state_wire         out  debug: IDLE=0, WAIT=1, SEND=2, DRAIN=3
// ---------------------------------------------------------------------------
module wless_tx_scheduler #(
  parameter int DATA_WIDTH                  = 8,
  parameter int COUNT_WIDTH                 = 10,
  parameter int START_WIRELESS_TRANS_VALUE  = 58,
  parameter int END_WAITING_SEND_WLESS_DATA = 6250,
  parameter int MAX_PACKET                  = 58
) (
  input  logic                   internal_clk,
  input  logic                   rst,
  input  logic                   enable,
  input  logic [COUNT_WIDTH-1:0] buf_count,
  input  logic [DATA_WIDTH-1:0]  buf_data,
  input  logic                   rx_byte_strobe,
  output logic                   buf_rd,
  input  logic                   TX_flag_node,
  input  logic                   TX_complete,
  output logic                   TX_use_node,
  output logic [DATA_WIDTH-1:0]  data_to_uart_node,
  output logic                   AUX,
  output logic [1:0]             state_wire
);

  // Counter widths sized so the terminal values fit without wrapping.
  localparam int TIMER_W = $clog2(END_WAITING_SEND_WLESS_DATA + 1);
  localparam int SENT_W  = $clog2(MAX_PACKET + 1);

  localparam logic [COUNT_WIDTH-1:0] START_C    = COUNT_WIDTH'(START_WIRELESS_TRANS_VALUE);
  localparam logic [TIMER_W-1:0]     TIMER_LAST = TIMER_W'(END_WAITING_SEND_WLESS_DATA - 1);
  localparam logic [SENT_W-1:0]      SENT_MAX   = SENT_W'(MAX_PACKET);
  localparam logic [SENT_W-1:0]      SENT_ONE   = SENT_W'(1);
  localparam logic [TIMER_W-1:0]     TIMER_ONE  = TIMER_W'(1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_SEND  = 2'd2,
    ST_DRAIN = 2'd3
  } state_e;

  state_e                  state_q, state_d;
  logic [TIMER_W-1:0]      timer_q, timer_d;
  logic [SENT_W-1:0]       sent_q, sent_d;
  logic                    gap_q, gap_d;
  logic                    push_q, push_d;
  logic [DATA_WIDTH-1:0]   data_q, data_d;
  logic                    aux_q;

  // Shared decode used by both the next-state and output processes.
  logic buf_empty;
  logic at_threshold;
  logic timer_done;
  logic sent_full;
  logic send_slot;   // SEND cycle allowed to act: not a gap, FIFO not full
  logic issue;

  assign buf_empty    = (buf_count == '0);
  assign at_threshold = (buf_count >= START_C);
  assign timer_done   = (timer_q == TIMER_LAST);
  assign sent_full    = (sent_q == SENT_MAX);
  assign send_slot    = (state_q == ST_SEND) && !gap_q && !TX_flag_node;
  assign issue        = send_slot && !buf_empty && !sent_full;

  // -------------------------------------------------------------------------
  // State register and registered outputs
  // -------------------------------------------------------------------------
  always_ff @(posedge internal_clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      timer_q <= '0;
      sent_q  <= '0;
      gap_q   <= 1'b0;
      push_q  <= 1'b0;
      data_q  <= '0;
      aux_q   <= 1'b1;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      sent_q  <= sent_d;
      gap_q   <= gap_d;
      push_q  <= push_d;
      data_q  <= data_d;
      // AUX follows the registered state so it is exactly "state == IDLE".
      aux_q   <= (state_d == ST_IDLE);
    end
  end

  // -------------------------------------------------------------------------
  // Next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (enable && at_threshold) begin
          state_d = ST_SEND;
        end else if (enable && !buf_empty) begin
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        // A strobe on the expiry cycle keeps us waiting.
        if (!enable || buf_empty) begin
          state_d = ST_IDLE;
        end else if (at_threshold) begin
          state_d = ST_SEND;
        end else if (timer_done && !rx_byte_strobe) begin
          state_d = ST_SEND;
        end
      end
      ST_SEND: begin
        // enable is deliberately ignored: a started packet always completes.
        if (send_slot && (buf_empty || sent_full)) begin
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (TX_complete) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // -------------------------------------------------------------------------
  // Output / counter logic
  // -------------------------------------------------------------------------
  always_comb begin
    timer_d = timer_q;
    sent_d  = sent_q;
    gap_d   = gap_q;
    push_d  = 1'b0;
    data_d  = data_q;
    unique case (state_q)
      ST_IDLE: begin
        // Cleared here so WAIT and SEND are both entered with fresh counters.
        timer_d = '0;
        sent_d  = '0;
        gap_d   = 1'b0;
      end
      ST_WAIT: begin
        sent_d = '0;
        gap_d  = 1'b0;
        if (rx_byte_strobe) begin
          timer_d = '0;
        end else if (!timer_done) begin
          timer_d = timer_q + TIMER_ONE;
        end
      end
      ST_SEND: begin
        if (gap_q) begin
          // Cycle in which the pop pulse is visible; the buffer head is stale.
          gap_d = 1'b0;
        end else if (issue) begin
          push_d = 1'b1;
          data_d = buf_data;
          sent_d = sent_q + SENT_ONE;
          gap_d  = 1'b1;
        end
      end
      ST_DRAIN: begin
        gap_d = 1'b0;
      end
      default: begin
        timer_d = '0;
        sent_d  = '0;
        gap_d   = 1'b0;
      end
    endcase
  end

  // One flop drives both pulses so they can never disagree.
  assign TX_use_node       = push_q;
  assign buf_rd            = push_q;
  assign data_to_uart_node = data_q;
  assign AUX               = aux_q;
  assign state_wire        = state_q;

endmodule
